regfile_checkpoint: RTL and testbench
=====================================

# regfile_checkpoint

Register-file checkpoint responder for the value-prediction recovery path. It captures a full architectural register snapshot on request from the hazard controller and, on mis-speculation, replays the saved values into the register file through its write port. Completion is reported back with done/ack handshakes. It sits between the hazard controller (initiator) and the decode-stage register file (restore target).

## Interface
- DATA_WIDTH, 32, register width
- NUM_REGS, 32, architectural registers; r0 is never captured-dependent or restored

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- take_snapshot  in  1  level request to capture regs_in
- regs_in  in  NUM_REGS x DATA_WIDTH  live register file contents
- snapshot_done  out  1  capture complete; held until snapshot_ack
- snapshot_ack  in  1  initiator acknowledges capture
- recover  in  1  request to restore the snapshot
- restore_we  out  1  register file write enable (restore path)
- restore_addr  out  5  register index being restored
- restore_data  out  DATA_WIDTH  saved value for restore_addr
- recovery_done  out  1  restore complete; held until recovery_done_ack
- recovery_done_ack  in  1  initiator acknowledges restore
- wb_we, wb_addr[4:0]  in  1, 5  writeback port observation (dirty tracking)
- regs_snapshot  out  NUM_REGS x DATA_WIDTH  parallel view of stored snapshot
- busy  out  1  high in RESTORE and RDONE

## Operation
- States: IDLE, CAPTURED, HELD, RESTORE, RDONE.
- IDLE: take_snapshot -> store regs_in[1..31], go CAPTURED. recover ignored (no valid snapshot).
- CAPTURED: snapshot_done=1. snapshot_ack -> HELD. recover -> RESTORE (ack no longer needed; snapshot_done drops).
- HELD: take_snapshot -> recapture (overwrite), go CAPTURED. recover -> RESTORE. Both same cycle: recover wins, no recapture.
- RESTORE: one write per cycle, restore_we=1, restore_addr=idx, restore_data=snap[idx]; idx runs 1..31 ascending; after idx 31 -> RDONE.
- RDONE: recovery_done=1 until recovery_done_ack, then IDLE; snapshot invalidated.
- take_snapshot ignored while busy. wb_we during RESTORE/RDONE ignored.
- restore_addr never 0; restore_data is the captured value, not regs_in.

## Timing
- Reset: state IDLE, storage and all outputs 0, dirty mask 0, idx 1.
- Capture: regs_in sampled on the edge where take_snapshot seen in IDLE/HELD; snapshot_done high next cycle.
- Restore latency (macro off): first restore_we the cycle after recover accepted; exactly 31 write cycles; recovery_done asserted cycle after last write.
- Ack handled on the edge it is seen; done output low the following cycle. Ack outside the matching state ignored.
- rst mid-RESTORE: writes stop next cycle, snapshot discarded, no recovery_done.

## Configuration
- CHECKPOINT_DIRTY_ONLY_EN defined: per-register dirty mask set by wb_we && wb_addr!=0 in CAPTURED/HELD; cleared on capture. A writeback on the capture edge sets its bit (regs_in is pre-write). RESTORE writes only dirty registers, ascending, one per cycle, no idle cycles between; write count = popcount(dirty). Zero dirty -> RESTORE lasts one cycle with restore_we=0, then RDONE.
- Undefined: wb_we/wb_addr unused; full 31-register replay.

## Structure
- Shared package: checkpoint_state_e enum, REG_ADDR_WIDTH=5, NUM_ARCH_REGS=32.
- Sub-module ckpt_dirty_scan: priority encoder returning the lowest set dirty index >= current idx plus a none-left flag; instantiated only under CHECKPOINT_DIRTY_ONLY_EN.

## Test plan
- Reset, then regs_in[k]=k*0x11 and take_snapshot 1 cycle -> snapshot_done high next cycle, regs_snapshot[5]=0x55; snapshot_ack -> done low next cycle.
- Capture, change regs_in, recover -> 31 writes addr 1..31 with captured data, recovery_done after addr 31; ack -> IDLE, busy low.
- take_snapshot and recover same cycle in HELD -> restore uses old snapshot; no snapshot_done.
- recover in IDLE -> no restore_we, no recovery_done, state IDLE.
- Macro on: capture, wb writes r3 and r17 (r3 on the capture edge), wb to r0 -> exactly two writes (3 then 17) on consecutive cycles, then recovery_done; no dirty -> recovery_done 2 cycles after recover.
- Assert rst at 10th restore write -> restore_we 0 next cycle, all outputs 0, subsequent recover ignored.

Source files
------------

// File: rtl/regfile_checkpoint_pkg.sv
// Shared types and sizes for the register-file checkpoint responder.
// Build option CHECKPOINT_DIRTY_ONLY_EN (see regfile_checkpoint.sv) does not change this package.
package regfile_checkpoint_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int NUM_ARCH_REGS  = 32;

   typedef enum logic [2:0] {
      CK_IDLE     = 3'd0,
      CK_CAPTURED = 3'd1,
      CK_HELD     = 3'd2,
      CK_RESTORE  = 3'd3,
      CK_RDONE    = 3'd4
   } checkpoint_state_e;

endpackage

// File: rtl/regfile_checkpoint_if.sv
// Hazard-controller / register-file side bundle of the checkpoint responder.
// master = initiator and environment, slave = regfile_checkpoint.
interface regfile_checkpoint_if
   import regfile_checkpoint_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = NUM_ARCH_REGS
) ();

   logic                                 take_snapshot;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_in;
   logic                                 snapshot_done;
   logic                                 snapshot_ack;
   logic                                 recover;
   logic                                 restore_we;
   logic [REG_ADDR_WIDTH-1:0]            restore_addr;
   logic [DATA_WIDTH-1:0]                restore_data;
   logic                                 recovery_done;
   logic                                 recovery_done_ack;
   logic                                 wb_we;
   logic [REG_ADDR_WIDTH-1:0]            wb_addr;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_snapshot;
   logic                                 busy;

   modport master (
      output take_snapshot, regs_in, snapshot_ack, recover, recovery_done_ack,
             wb_we, wb_addr,
      input  snapshot_done, restore_we, restore_addr, restore_data,
             recovery_done, regs_snapshot, busy
   );

   modport slave (
      input  take_snapshot, regs_in, snapshot_ack, recover, recovery_done_ack,
             wb_we, wb_addr,
      output snapshot_done, restore_we, restore_addr, restore_data,
             recovery_done, regs_snapshot, busy
   );

endinterface

// File: rtl/regfile_checkpoint_ckpt_dirty_scan.sv
// Priority encoder: lowest set dirty bit at or above i_start, plus a none-left flag.
// Only instantiated when CHECKPOINT_DIRTY_ONLY_EN is defined.
module ckpt_dirty_scan
   import regfile_checkpoint_pkg::*;
#(
   parameter int NUM_REGS = NUM_ARCH_REGS
) (
   input  logic [NUM_REGS-1:0]       i_dirty,
   input  logic [REG_ADDR_WIDTH:0]   i_start,
   output logic [REG_ADDR_WIDTH-1:0] o_idx,
   output logic                      o_none
);

   always_comb begin
      o_idx  = '0;
      o_none = 1'b1;
      // Descending walk so the lowest qualifying index is the last one written.
      for (int k = NUM_REGS - 1; k >= 0; k--) begin
         if (i_dirty[k] && ((REG_ADDR_WIDTH + 1)'(k) >= i_start)) begin
            o_idx  = REG_ADDR_WIDTH'(k);
            o_none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/regfile_checkpoint.sv
// Register-file checkpoint responder: captures r1..r31, replays them through the write port on recover.
// Define CHECKPOINT_DIRTY_ONLY_EN to replay only registers written back since the capture.
module regfile_checkpoint
   import regfile_checkpoint_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = NUM_ARCH_REGS
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_checkpoint_if.slave  bus
);

   localparam logic [2:0] ST_IDLE     = CK_IDLE;
   localparam logic [2:0] ST_CAPTURED = CK_CAPTURED;
   localparam logic [2:0] ST_HELD     = CK_HELD;
   localparam logic [2:0] ST_RESTORE  = CK_RESTORE;
   localparam logic [2:0] ST_RDONE    = CK_RDONE;

   logic [2:0]                           r_state;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  r_snap;
   logic [REG_ADDR_WIDTH-1:0]            r_idx;

   logic                      w_rec_accept;
   logic                      w_cap;
   logic                      w_wr_en;
   logic [REG_ADDR_WIDTH-1:0] w_wr_addr;
   logic [REG_ADDR_WIDTH-1:0] w_idx_next;
   logic                      w_last;
   logic                      w_unused_r0;

   assign w_unused_r0  = ^bus.regs_in[0];

   // recover outranks a same-cycle take_snapshot in HELD
   assign w_rec_accept = bus.recover && (r_state == ST_CAPTURED || r_state == ST_HELD);
   assign w_cap        = bus.take_snapshot && !w_rec_accept &&
                         (r_state == ST_IDLE || r_state == ST_HELD);

`ifdef CHECKPOINT_DIRTY_ONLY_EN
   logic [NUM_REGS-1:0]       r_dirty;
   logic [NUM_REGS-1:0]       w_wb_mask;
   logic [REG_ADDR_WIDTH-1:0] w_cur_idx;
   logic                      w_cur_none;
   logic [REG_ADDR_WIDTH-1:0] w_nxt_idx_unused;
   logic                      w_nxt_none;

   assign w_wb_mask = (bus.wb_we && bus.wb_addr != '0) ?
                      (NUM_REGS'(1) << bus.wb_addr) : '0;

   ckpt_dirty_scan #(.NUM_REGS(NUM_REGS)) u_scan_cur (
      .i_dirty (r_dirty),
      .i_start ({1'b0, r_idx}),
      .o_idx   (w_cur_idx),
      .o_none  (w_cur_none)
   );

   // Look one write ahead so the final dirty write goes straight to RDONE.
   ckpt_dirty_scan #(.NUM_REGS(NUM_REGS)) u_scan_nxt (
      .i_dirty (r_dirty),
      .i_start ({1'b0, w_cur_idx} + (REG_ADDR_WIDTH + 1)'(1)),
      .o_idx   (w_nxt_idx_unused),
      .o_none  (w_nxt_none)
   );

   assign w_wr_en    = (r_state == ST_RESTORE) && !w_cur_none;
   assign w_wr_addr  = w_cur_idx;
   assign w_last     = w_cur_none || w_nxt_none;
   assign w_idx_next = w_cur_idx + REG_ADDR_WIDTH'(1);

   // A writeback on the capture edge counts: regs_in holds the pre-write value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dirty <= '0;
      end else if (w_cap) begin
         r_dirty <= w_wb_mask;
      end else if (r_state == ST_CAPTURED || r_state == ST_HELD) begin
         r_dirty <= r_dirty | w_wb_mask;
      end
   end
`else
   logic w_unused_wb;

   assign w_unused_wb = ^{bus.wb_we, bus.wb_addr};
   assign w_wr_en     = (r_state == ST_RESTORE);
   assign w_wr_addr   = r_idx;
   assign w_last      = (r_idx == '1);
   assign w_idx_next  = r_idx + REG_ADDR_WIDTH'(1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_snap  <= '0;
         r_idx   <= REG_ADDR_WIDTH'(1);
      end else begin
         if (w_cap) begin
            for (int k = 1; k < NUM_REGS; k++) begin
               r_snap[k] <= bus.regs_in[k];
            end
         end
         case (r_state)
            ST_IDLE: begin
               if (w_cap) r_state <= ST_CAPTURED;
            end
            ST_CAPTURED: begin
               if (w_rec_accept) begin
                  r_state <= ST_RESTORE;
                  r_idx   <= REG_ADDR_WIDTH'(1);
               end else if (bus.snapshot_ack) begin
                  r_state <= ST_HELD;
               end
            end
            ST_HELD: begin
               if (w_rec_accept) begin
                  r_state <= ST_RESTORE;
                  r_idx   <= REG_ADDR_WIDTH'(1);
               end else if (w_cap) begin
                  r_state <= ST_CAPTURED;
               end
            end
            ST_RESTORE: begin
               if (w_last) begin
                  r_state <= ST_RDONE;
                  r_idx   <= REG_ADDR_WIDTH'(1);
               end else begin
                  r_idx   <= w_idx_next;
               end
            end
            ST_RDONE: begin
               if (bus.recovery_done_ack) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.snapshot_done = (r_state == ST_CAPTURED);
   assign bus.recovery_done = (r_state == ST_RDONE);
   assign bus.busy          = (r_state == ST_RESTORE) || (r_state == ST_RDONE);
   assign bus.restore_we    = w_wr_en;
   assign bus.restore_addr  = w_wr_en ? w_wr_addr : '0;
   assign bus.restore_data  = w_wr_en ? r_snap[w_wr_addr] : '0;
   assign bus.regs_snapshot = r_snap;

endmodule

// File: tb/tb_regfile_checkpoint.sv
// Directed bench for regfile_checkpoint; covers full replay or, with CHECKPOINT_DIRTY_ONLY_EN, dirty-only replay.
module tb_regfile_checkpoint;
   import regfile_checkpoint_pkg::*;

   localparam int DW = 32;
   localparam int NR = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   regfile_checkpoint_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) u_if ();

   regfile_checkpoint #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      u_if.take_snapshot     = 1'b0;
      u_if.snapshot_ack      = 1'b0;
      u_if.recover           = 1'b0;
      u_if.recovery_done_ack = 1'b0;
      u_if.wb_we             = 1'b0;
      u_if.wb_addr           = '0;
   endtask

   task automatic set_regs(input logic [31:0] mul, input logic [31:0] add);
      for (int k = 0; k < NR; k++) u_if.regs_in[k] = 32'(k) * mul + add;
   endtask

   task automatic test_reset();
      idle_inputs();
      set_regs(32'h0, 32'hFFFF_FFFF);
      rst = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({u_if.snapshot_done, u_if.recovery_done, u_if.restore_we, u_if.busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 0000",
                  {u_if.snapshot_done, u_if.recovery_done, u_if.restore_we, u_if.busy});
      end
      n_tests++;
      if ({u_if.restore_addr, u_if.restore_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_addr_data got %h/%h want 0/0", u_if.restore_addr, u_if.restore_data);
      end
      n_tests++;
      if (u_if.regs_snapshot !== '0) begin
         n_fail++;
         $display("FAIL reset_snapshot got nonzero want 0");
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_capture();
      set_regs(32'h11, 32'h0);
      u_if.take_snapshot = 1'b1;
      tick();
      u_if.take_snapshot = 1'b0;
      set_regs(32'h0, 32'hDEAD_0000);
      n_tests++;
      if (u_if.snapshot_done !== 1'b1) begin
         n_fail++;
         $display("FAIL cap_done got %b want 1", u_if.snapshot_done);
      end
      n_tests++;
      if (u_if.regs_snapshot[5] !== 32'h55) begin
         n_fail++;
         $display("FAIL cap_r5 got %h want 00000055", u_if.regs_snapshot[5]);
      end
      n_tests++;
      if (u_if.regs_snapshot[31] !== 32'h20F) begin
         n_fail++;
         $display("FAIL cap_r31 got %h want 0000020f", u_if.regs_snapshot[31]);
      end
      n_tests++;
      if (u_if.regs_snapshot[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL cap_r0 got %h want 0", u_if.regs_snapshot[0]);
      end
      tick();
      n_tests++;
      if (u_if.snapshot_done !== 1'b1) begin
         n_fail++;
         $display("FAIL cap_done_held got %b want 1", u_if.snapshot_done);
      end
      u_if.snapshot_ack = 1'b1;
      tick();
      u_if.snapshot_ack = 1'b0;
      n_tests++;
      if ({u_if.snapshot_done, u_if.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL cap_ack got done/busy %b want 00", {u_if.snapshot_done, u_if.busy});
      end
   endtask

`ifndef CHECKPOINT_DIRTY_ONLY_EN
   task automatic test_full_restore();
      u_if.recover = 1'b1;
      tick();
      u_if.recover = 1'b0;
      for (int i = 1; i < NR; i++) begin
         n_tests++;
         if ({u_if.restore_we, u_if.restore_addr, u_if.restore_data} !==
             {1'b1, 5'(i), 32'(i) * 32'h11}) begin
            n_fail++;
            $display("FAIL full_wr%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                     i, u_if.restore_we, u_if.restore_addr, u_if.restore_data, i, 32'(i) * 32'h11);
         end
         tick();
      end
      n_tests++;
      if ({u_if.restore_we, u_if.recovery_done, u_if.busy} !== 3'b011) begin
         n_fail++;
         $display("FAIL full_rdone got we/done/busy %b want 011",
                  {u_if.restore_we, u_if.recovery_done, u_if.busy});
      end
      tick();
      n_tests++;
      if (u_if.recovery_done !== 1'b1) begin
         n_fail++;
         $display("FAIL full_rdone_held got %b want 1", u_if.recovery_done);
      end
      u_if.recovery_done_ack = 1'b1;
      tick();
      u_if.recovery_done_ack = 1'b0;
      n_tests++;
      if ({u_if.recovery_done, u_if.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL full_ack got done/busy %b want 00", {u_if.recovery_done, u_if.busy});
      end
   endtask
`else
   task automatic test_dirty_restore();
      set_regs(32'h11, 32'h0);
      u_if.take_snapshot = 1'b1;
      u_if.wb_we         = 1'b1;
      u_if.wb_addr       = 5'd3;
      tick();
      u_if.take_snapshot = 1'b0;
      u_if.wb_addr       = 5'd17;
      tick();
      u_if.wb_addr       = 5'd0;
      tick();
      u_if.wb_we         = 1'b0;
      u_if.snapshot_ack  = 1'b1;
      tick();
      u_if.snapshot_ack  = 1'b0;
      u_if.recover       = 1'b1;
      tick();
      u_if.recover       = 1'b0;
      n_tests++;
      if ({u_if.restore_we, u_if.restore_addr, u_if.restore_data} !== {1'b1, 5'd3, 32'h33}) begin
         n_fail++;
         $display("FAIL dirty_wr1 got we=%b addr=%0d data=%h want we=1 addr=3 data=00000033",
                  u_if.restore_we, u_if.restore_addr, u_if.restore_data);
      end
      tick();
      n_tests++;
      if ({u_if.restore_we, u_if.restore_addr, u_if.restore_data} !== {1'b1, 5'd17, 32'h121}) begin
         n_fail++;
         $display("FAIL dirty_wr2 got we=%b addr=%0d data=%h want we=1 addr=17 data=00000121",
                  u_if.restore_we, u_if.restore_addr, u_if.restore_data);
      end
      tick();
      n_tests++;
      if ({u_if.restore_we, u_if.recovery_done} !== 2'b01) begin
         n_fail++;
         $display("FAIL dirty_rdone got we/done %b want 01", {u_if.restore_we, u_if.recovery_done});
      end
      u_if.recovery_done_ack = 1'b1;
      tick();
      u_if.recovery_done_ack = 1'b0;
      n_tests++;
      if (u_if.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL dirty_ack got busy %b want 0", u_if.busy);
      end
   endtask

   task automatic test_dirty_none();
      set_regs(32'h11, 32'h0);
      u_if.take_snapshot = 1'b1;
      tick();
      u_if.take_snapshot = 1'b0;
      u_if.recover       = 1'b1;
      tick();
      u_if.recover       = 1'b0;
      n_tests++;
      if ({u_if.restore_we, u_if.recovery_done, u_if.busy, u_if.snapshot_done} !== 4'b0010) begin
         n_fail++;
         $display("FAIL none_restore got we/done/busy/sdone %b want 0010",
                  {u_if.restore_we, u_if.recovery_done, u_if.busy, u_if.snapshot_done});
      end
      tick();
      n_tests++;
      if ({u_if.restore_we, u_if.recovery_done} !== 2'b01) begin
         n_fail++;
         $display("FAIL none_rdone got we/done %b want 01", {u_if.restore_we, u_if.recovery_done});
      end
      u_if.recovery_done_ack = 1'b1;
      tick();
      u_if.recovery_done_ack = 1'b0;
   endtask
`endif

   task automatic test_recover_idle();
      u_if.recover = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_tests++;
         if ({u_if.restore_we, u_if.recovery_done, u_if.busy, u_if.snapshot_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_recover%0d got we/done/busy/sdone %b want 0000", c,
                     {u_if.restore_we, u_if.recovery_done, u_if.busy, u_if.snapshot_done});
         end
      end
      u_if.recover = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit seen;
      set_regs(32'h11, 32'h0);
      u_if.take_snapshot = 1'b1;
      tick();
      u_if.take_snapshot = 1'b0;
      u_if.snapshot_ack  = 1'b1;
      tick();
      u_if.snapshot_ack  = 1'b0;
      set_regs(32'h1, 32'h100);
      u_if.take_snapshot = 1'b1;
      u_if.recover       = 1'b1;
      tick();
      u_if.take_snapshot = 1'b0;
      u_if.recover       = 1'b0;
      n_tests++;
      if ({u_if.snapshot_done, u_if.busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_state got sdone/busy %b want 01", {u_if.snapshot_done, u_if.busy});
      end
      n_tests++;
      if (u_if.regs_snapshot[1] !== 32'h11) begin
         n_fail++;
         $display("FAIL b2b_keep_old got %h want 00000011", u_if.regs_snapshot[1]);
      end
`ifndef CHECKPOINT_DIRTY_ONLY_EN
      n_tests++;
      if ({u_if.restore_we, u_if.restore_addr, u_if.restore_data} !== {1'b1, 5'd1, 32'h11}) begin
         n_fail++;
         $display("FAIL b2b_first_wr got we=%b addr=%0d data=%h want we=1 addr=1 data=00000011",
                  u_if.restore_we, u_if.restore_addr, u_if.restore_data);
      end
`endif
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (u_if.recovery_done === 1'b1) seen = 1'b1;
         else tick();
      end
      n_tests++;
      if (seen !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_rdone_timeout got 0 want 1");
      end
      u_if.recovery_done_ack = 1'b1;
      tick();
      u_if.recovery_done_ack = 1'b0;
   endtask

   task automatic test_reset_mid_restore();
      bit          seen;
      logic [4:0]  target;
`ifdef CHECKPOINT_DIRTY_ONLY_EN
      target = 5'd17;
`else
      target = 5'd10;
`endif
      set_regs(32'h11, 32'h0);
      u_if.take_snapshot = 1'b1;
      u_if.wb_we         = 1'b1;
      u_if.wb_addr       = 5'd3;
      tick();
      u_if.take_snapshot = 1'b0;
      u_if.wb_addr       = 5'd17;
      tick();
      u_if.wb_we         = 1'b0;
      u_if.wb_addr       = 5'd0;
      u_if.recover       = 1'b1;
      tick();
      u_if.recover       = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (u_if.restore_we === 1'b1 && u_if.restore_addr === target) seen = 1'b1;
         else tick();
      end
      n_tests++;
      if (seen !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_reach got 0 want 1 (addr %0d)", target);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if ({u_if.restore_we, u_if.recovery_done, u_if.busy, u_if.snapshot_done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rstmid_flags got we/done/busy/sdone %b want 0000",
                  {u_if.restore_we, u_if.recovery_done, u_if.busy, u_if.snapshot_done});
      end
      n_tests++;
      if (u_if.regs_snapshot !== '0) begin
         n_fail++;
         $display("FAIL rstmid_snapshot got nonzero want 0");
      end
      rst = 1'b0;
      u_if.recover = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_tests++;
         if ({u_if.restore_we, u_if.recovery_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_recover%0d got we/done %b want 00", c,
                     {u_if.restore_we, u_if.recovery_done});
         end
      end
      u_if.recover = 1'b0;
   endtask

   initial begin
      test_reset();
      test_capture();
`ifdef CHECKPOINT_DIRTY_ONLY_EN
      test_dirty_restore();
      test_dirty_none();
`else
      test_full_restore();
`endif
      test_recover_idle();
      test_back_to_back();
      test_reset_mid_restore();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
